// File: rtl/tff_updown_counter.sv
// Up/down counter built from per-bit toggle cells, with a zero-latency terminal count and a registered wrap pulse.
// Optional registered complement output qbar is enabled by defining TFF_QBAR_OUT_EN.
module tff_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
`ifdef TFF_QBAR_OUT_EN
  ,
  output logic [WIDTH-1:0] qbar
`endif
);

  localparam int              MOD_BITS = $clog2(MODULUS);
  localparam bit              IS_POW2  = ((MODULUS & (MODULUS - 1)) == 0);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] q_next;

  assign at_max   = (q == MAX_VAL);
  assign at_zero  = (q == '0);
  assign tc       = en & ~load & ((up & at_max) | (~up & at_zero));
  // Out-of-range load values saturate to the top count instead of wrapping.
  assign load_val = (d > MAX_VAL) ? MAX_VAL : d;

  generate
    if (IS_POW2) begin : g_chain
      logic [WIDTH-1:0] up_carry;
      logic [WIDTH-1:0] dn_borrow;

      assign up_carry[0]  = 1'b1;
      assign dn_borrow[0] = 1'b1;
      for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
        assign up_carry[gi]  = up_carry[gi-1] & q[gi-1];
        assign dn_borrow[gi] = dn_borrow[gi-1] & ~q[gi-1];
      end
      // Bits above log2(MODULUS) never toggle, so unused codes stay unreachable.
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_toggle
        if (gi < MOD_BITS) begin : g_live
          assign t[gi] = en & (up ? up_carry[gi] : dn_borrow[gi]);
        end else begin : g_dead
          assign t[gi] = 1'b0;
        end
      end
    end else begin : g_compare
      logic [WIDTH-1:0] step_val;

      always_comb begin
        step_val = q;
        if (up) begin
          step_val = at_max ? '0 : q + WIDTH'(1);
        end else begin
          step_val = at_zero ? MAX_VAL : q - WIDTH'(1);
        end
      end
      // Toggle exactly the bits that differ from the wrapped next count.
      assign t = en ? (q ^ step_val) : '0;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tcell
      assign q_next[gi] = load ? load_val[gi] : (q[gi] ^ t[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= tc;
    end
  end

`ifdef TFF_QBAR_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      qbar <= '1;
    end else begin
      qbar <= ~q_next;
    end
  end
`endif

endmodule

// File: tb/tb_tff_updown_counter.sv
// Directed bench for tff_updown_counter: a MODULUS=16 instance and a MODULUS=10 instance share stimulus.
// Checks qbar as well when TFF_QBAR_OUT_EN is defined.
module tb_tff_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] d;
  logic [3:0] q16, q10;
  logic       tc16, tc10, wrap16, wrap10;
`ifdef TFF_QBAR_OUT_EN
  logic [3:0] qbar16, qbar10;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  tff_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .q(q16), .tc(tc16), .wrap(wrap16)
`ifdef TFF_QBAR_OUT_EN
    , .qbar(qbar16)
`endif
  );

  tff_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .q(q10), .tc(tc10), .wrap(wrap10)
`ifdef TFF_QBAR_OUT_EN
    , .qbar(qbar10)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = 4'd0;
    step(); step();
    rst = 1'b0;
    step();
    compared++;
    if (q16 !== 4'd0) begin mismatched++; $display("FAIL reset_q16: got %0d want 0", q16); end
    compared++;
    if (q10 !== 4'd0) begin mismatched++; $display("FAIL reset_q10: got %0d want 0", q10); end
    compared++;
    if (wrap16 !== 1'b0) begin mismatched++; $display("FAIL reset_wrap: got %b want 0", wrap16); end
    compared++;
    if (tc16 !== 1'b0) begin mismatched++; $display("FAIL reset_tc: got %b want 0", tc16); end
`ifdef TFF_QBAR_OUT_EN
    compared++;
    if (qbar16 !== 4'hF) begin mismatched++; $display("FAIL reset_qbar: got %h want f", qbar16); end
`endif
    $display("test_reset: q16=%0d q10=%0d tc=%b wrap=%b", q16, q10, tc16, wrap16);
  endtask

  task automatic test_count_up16();
    logic [3:0] exp_q;
    up = 1'b1; en = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      exp_q = 4'(k % 16);
      compared++;
      if (q16 !== exp_q) begin mismatched++; $display("FAIL up16_q k=%0d: got %0d want %0d", k, q16, exp_q); end
      compared++;
      if (tc16 !== (exp_q == 4'd15)) begin mismatched++; $display("FAIL up16_tc k=%0d: got %b want %b", k, tc16, exp_q == 4'd15); end
      compared++;
      if (wrap16 !== (k == 16)) begin mismatched++; $display("FAIL up16_wrap k=%0d: got %b want %b", k, wrap16, k == 16); end
`ifdef TFF_QBAR_OUT_EN
      compared++;
      if (qbar16 !== ~exp_q) begin mismatched++; $display("FAIL up16_qbar k=%0d: got %h want %h", k, qbar16, ~exp_q); end
`endif
      $display("test_count_up16: k=%0d q=%0d tc=%b wrap=%b", k, q16, tc16, wrap16);
      step();
    end
    en = 1'b0;
  endtask

  task automatic test_count_down10();
    logic [3:0] exp_q;
    load = 1'b1; d = 4'd9; en = 1'b0;
    step();
    load = 1'b0; up = 1'b0; en = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      exp_q = (k <= 9) ? 4'(9 - k) : 4'd9;
      compared++;
      if (q10 !== exp_q) begin mismatched++; $display("FAIL down10_q k=%0d: got %0d want %0d", k, q10, exp_q); end
      compared++;
      if (tc10 !== (exp_q == 4'd0)) begin mismatched++; $display("FAIL down10_tc k=%0d: got %b want %b", k, tc10, exp_q == 4'd0); end
      compared++;
      if (wrap10 !== (k == 10)) begin mismatched++; $display("FAIL down10_wrap k=%0d: got %b want %b", k, wrap10, k == 10); end
      $display("test_count_down10: k=%0d q=%0d tc=%b wrap=%b", k, q10, tc10, wrap10);
      step();
    end
    en = 1'b0;
  endtask

  task automatic test_load();
    load = 1'b1; d = 4'hC; en = 1'b0; up = 1'b1;
    step();
    compared++;
    if (q10 !== 4'd9) begin mismatched++; $display("FAIL load_sat10: got %0d want 9", q10); end
    compared++;
    if (q16 !== 4'd12) begin mismatched++; $display("FAIL load_16: got %0d want 12", q16); end
    $display("test_load: saturate q10=%0d q16=%0d", q10, q16);
    // At q=9 counting up, a concurrent load must suppress tc and the step.
    load = 1'b1; en = 1'b1; d = 4'd3;
    #1;
    compared++;
    if (tc10 !== 1'b0) begin mismatched++; $display("FAIL load_tc_mask: got %b want 0", tc10); end
    step();
    compared++;
    if (q10 !== 4'd3) begin mismatched++; $display("FAIL load_over_en10: got %0d want 3", q10); end
    compared++;
    if (wrap10 !== 1'b0) begin mismatched++; $display("FAIL load_wrap10: got %b want 0", wrap10); end
    compared++;
    if (q16 !== 4'd3) begin mismatched++; $display("FAIL load_over_en16: got %0d want 3", q16); end
    $display("test_load: load+en q10=%0d q16=%0d wrap=%b", q10, q16, wrap10);
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_reset_midcount();
    load = 1'b1; d = 4'd7; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    compared++;
    if (q16 !== 4'd7) begin mismatched++; $display("FAIL midrst_pre: got %0d want 7", q16); end
    rst = 1'b1; load = 1'b1; d = 4'd5;
    step();
    rst = 1'b0; load = 1'b0; en = 1'b0;
    compared++;
    if (q16 !== 4'd0) begin mismatched++; $display("FAIL midrst_q: got %0d want 0", q16); end
    compared++;
    if (wrap16 !== 1'b0) begin mismatched++; $display("FAIL midrst_wrap: got %b want 0", wrap16); end
`ifdef TFF_QBAR_OUT_EN
    compared++;
    if (qbar16 !== 4'hF) begin mismatched++; $display("FAIL midrst_qbar: got %h want f", qbar16); end
`endif
    $display("test_reset_midcount: q=%0d wrap=%b", q16, wrap16);
  endtask

  task automatic test_direction_change();
    logic [3:0] exp_q [3] = '{4'd6, 4'd6, 4'd5};
    logic       en_seq[3] = '{1'b1, 1'b0, 1'b1};
    logic       up_seq[3] = '{1'b1, 1'b0, 1'b0};
    load = 1'b1; d = 4'd5; en = 1'b0;
    step();
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      en = en_seq[k]; up = up_seq[k];
      #1;
      compared++;
      if (tc16 !== 1'b0) begin mismatched++; $display("FAIL dir_tc k=%0d: got %b want 0", k, tc16); end
      step();
      compared++;
      if (q16 !== exp_q[k]) begin mismatched++; $display("FAIL dir_q k=%0d: got %0d want %0d", k, q16, exp_q[k]); end
      $display("test_direction_change: k=%0d en=%b up=%b q=%0d tc=%b", k, en, up, q16, tc16);
    end
    en = 1'b0;
  endtask

  task automatic test_down_wrap16();
    load = 1'b1; d = 4'd0; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    #1;
    compared++;
    if (tc16 !== 1'b1) begin mismatched++; $display("FAIL dwrap16_tc: got %b want 1", tc16); end
    step();
    en = 1'b0;
    compared++;
    if (q16 !== 4'd15) begin mismatched++; $display("FAIL dwrap16_q: got %0d want 15", q16); end
    compared++;
    if (wrap16 !== 1'b1) begin mismatched++; $display("FAIL dwrap16_wrap: got %b want 1", wrap16); end
    step();
    compared++;
    if (wrap16 !== 1'b0) begin mismatched++; $display("FAIL dwrap16_wrap_clear: got %b want 0", wrap16); end
    compared++;
    if (q16 !== 4'd15) begin mismatched++; $display("FAIL dwrap16_hold: got %0d want 15", q16); end
    $display("test_down_wrap16: q=%0d wrap=%b", q16, wrap16);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = 4'd0;
    #2;
    test_reset();
    test_count_up16();
    test_count_down10();
    test_load();
    test_reset_midcount();
    test_direction_change();
    test_down_wrap16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
